fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_buf.sv | 54 +++++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
// PC select encodings, the NOP word and the fetch buffer entry layout.
package fetch_unit_pkg;

    localparam logic [1:0] PCSEL_PLUS4 = 2'd0;
    localparam logic [1:0] PCSEL_ALU = 2'd1;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic {
        ST_BOOT,
        ST_RUN
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry in-order buffer of fetched {inst, pc} pairs.
// Flush has priority; push and pop may coincide at any occupancy.
module fetch_buf #(
    parameter logic [63:0] RESET_DATA = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [63:0] din,
    output logic        full,
    output logic        empty,
    output logic [63:0] dout
);

    logic [63:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        do_push;
    logic        do_pop;

    assign full = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= RESET_DATA;
            mem[1] <= RESET_DATA;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count <= 2'd0;
        end else begin
            // When full, the write slot is the head being popped this cycle.
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one-cycle icache request/response, 2-entry buffer,
// epoch-tagged kill/redirect handling.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  PC_Sel,
    input  logic        Inst_Kill,
    input  logic [31:0] alu_target,
    output logic        icache_req_valid,
    input  logic        icache_req_ready,
    output logic [31:0] icache_addr,
    input  logic        icache_resp_valid,
    input  logic [31:0] icache_dout,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        decode_ready
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [31:0]  fpc;
    logic         outstanding;
    logic         out_epoch;
    logic [31:0]  out_pc;
    logic         epoch;
    logic         epoch_next;

    logic         kill;
    logic         accept;
    logic         pop;
    logic         resp_ok;
    logic         can_issue;
    logic         buf_full;
    logic         buf_empty;
    fetch_entry_t head;
    fetch_entry_t resp_entry;

    assign kill = reset && (Inst_Kill || (PC_Sel != PCSEL_PLUS4));
    assign inst_valid = reset && !buf_empty && !kill;
    assign pop = inst_valid && decode_ready;
    assign accept = icache_req_valid && icache_req_ready;
    assign icache_addr = kill ? alu_target : fpc;
    assign epoch_next = kill ? ~epoch : epoch;

    // The single outstanding response always lands next cycle, so a pop
    // in the same cycle frees the slot it would otherwise need.
    assign can_issue = !buf_full && (buf_empty || !outstanding || pop);

    assign resp_ok = icache_resp_valid && outstanding
                     && (out_epoch == epoch) && !kill;
    assign resp_entry = '{inst: icache_dout, pc: out_pc};

    assign inst = reset ? head.inst : INST_NOP;
    assign inst_pc = reset ? head.pc : RESET_PC;

    always_comb begin
        state_next = state;
        icache_req_valid = 1'b0;
        unique case (state)
            ST_BOOT: begin
                state_next = ST_RUN;
                icache_req_valid = reset;
            end
            ST_RUN: begin
                icache_req_valid = reset && (kill || can_issue);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_BOOT;
            fpc <= RESET_PC;
            outstanding <= 1'b0;
            out_epoch <= 1'b0;
            out_pc <= RESET_PC;
            epoch <= 1'b0;
        end else begin
            state <= state_next;
            epoch <= epoch_next;
            outstanding <= accept;
            if (accept) begin
                out_pc <= icache_addr;
                out_epoch <= epoch_next;
                fpc <= icache_addr + 32'd4;
            end else if (kill) begin
                // Unaccepted redirect: hold the target until it is taken.
                fpc <= alu_target;
            end
        end
    end

    fetch_buf #(
        .RESET_DATA({INST_NOP, RESET_PC})
    ) u_buf (
        .clk   (clk),
        .rst   (~reset),
        .push  (resp_ok),
        .pop   (pop),
        .flush (kill),
        .din   (resp_entry),
        .full  (buf_full),
        .empty (buf_empty),
        .dout  (head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: icache model, directed scenarios, random traffic,
// scoreboard of the expected instruction stream.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RPC = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  PC_Sel;
    logic        Inst_Kill;
    logic [31:0] alu_target;
    logic        icache_req_valid;
    logic        icache_req_ready;
    logic [31:0] icache_addr;
    logic        icache_resp_valid;
    logic [31:0] icache_dout;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        decode_ready;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk               (clk),
        .reset             (reset),
        .PC_Sel            (PC_Sel),
        .Inst_Kill         (Inst_Kill),
        .alu_target        (alu_target),
        .icache_req_valid  (icache_req_valid),
        .icache_req_ready  (icache_req_ready),
        .icache_addr       (icache_addr),
        .icache_resp_valid (icache_resp_valid),
        .icache_dout       (icache_dout),
        .inst              (inst),
        .inst_pc           (inst_pc),
        .inst_valid        (inst_valid),
        .decode_ready      (decode_ready)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] next_exp;
    logic [31:0] fetch_model;
    logic        acc_seen = 1'b0;
    logic [31:0] acc_addr = '0;
    logic        inject_stale = 1'b0;
    logic        kill_prev = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          pops = 0;
    int          p0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    function automatic void model_restart(input logic [31:0] pc);
        exp_q.delete();
        next_exp = pc;
    endfunction

    function automatic void model_topup();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: next_exp, inst: mem_word(next_exp)});
            next_exp = next_exp + 32'd4;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst_n, input logic rdy, input logic dr,
                         input logic k, input logic [31:0] tgt);
        reset = rst_n;
        icache_req_ready = rdy;
        decode_ready = dr;
        Inst_Kill = k;
        PC_Sel = k ? PCSEL_ALU : PCSEL_PLUS4;
        alu_target = tgt;
        if (!rst_n) model_restart(RPC);
        else if (k) model_restart(tgt);
        model_topup();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        end
    endtask

    // icache: response exactly one cycle after an accepted request
    initial begin
        icache_resp_valid = 1'b0;
        icache_dout = '0;
        forever begin
            @(posedge clk);
            #1;
            if (inject_stale) begin
                icache_resp_valid = 1'b1;
                icache_dout = 32'hDEAD_BEEF;
                inject_stale = 1'b0;
            end else begin
                icache_resp_valid = acc_seen;
                icache_dout = acc_seen ? mem_word(acc_addr) : 32'h0;
            end
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        acc_seen = 1'b0;
        if (!reset) begin
            check("rst_inst_valid", 32'(inst_valid), 32'd0);
            check("rst_req_valid", 32'(icache_req_valid), 32'd0);
            check("rst_inst", inst, INST_NOP);
            check("rst_inst_pc", inst_pc, RPC);
            fetch_model = RPC;
        end else begin
            if (kill_prev) check("kill_latency", 32'(inst_valid), 32'd0);
            if (Inst_Kill) begin
                check("kill_inst_valid", 32'(inst_valid), 32'd0);
                check("kill_req_valid", 32'(icache_req_valid), 32'd1);
                check("kill_addr", icache_addr, alu_target);
                fetch_model = alu_target;
            end
            if (inst_valid && decode_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_empty: got pc %h, required none", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", inst_pc, e.pc);
                    check("sb_inst", inst, e.inst);
                    pops++;
                end
            end
            if (icache_req_valid && icache_req_ready) begin
                check("fetch_addr", icache_addr, fetch_model);
                fetch_model = icache_addr + 32'd4;
                acc_seen = 1'b1;
                acc_addr = icache_addr;
            end
        end
        kill_prev = reset && Inst_Kill;
    end

    initial begin
        reset = 1'b0;
        icache_req_ready = 1'b1;
        decode_ready = 1'b1;
        Inst_Kill = 1'b0;
        PC_Sel = PCSEL_PLUS4;
        alu_target = '0;
        model_restart(RPC);
        model_topup();
        repeat (2) begin
            step();
            drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        end
        @(negedge clk);
        inject_stale = 1'b1;

        // release: sequential fetch, first inst two cycles later
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("boot_addr", icache_addr, RPC);
        check("boot_req_valid", 32'(icache_req_valid), 32'd1);
        check("c0_inst_valid", 32'(inst_valid), 32'd0);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("c1_addr", icache_addr, RPC + 32'd4);
        check("c1_inst_valid", 32'(inst_valid), 32'd0);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("c2_addr", icache_addr, RPC + 32'd8);
        check("c2_inst_valid", 32'(inst_valid), 32'd1);
        check("c2_inst_pc", inst_pc, RPC);

        step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        p0 = pops;
        run(10);
        check("throughput", 32'(pops - p0), 32'd10);

        // decode stall: buffer fills, requests stop
        for (int i = 0; i < 5; i++) begin
            step();
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        end
        @(negedge clk);
        check("stall_req_valid", 32'(icache_req_valid), 32'd0);
        check("stall_inst_valid", 32'(inst_valid), 32'd1);
        check("stall_head_pc", inst_pc, exp_q[0].pc);
        run(6);

        // kill with two buffered
        for (int i = 0; i < 3; i++) begin
            step();
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        end
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h4000_0100);
        run(2);
        @(negedge clk);
        check("redir_inst_valid", 32'(inst_valid), 32'd1);
        check("redir_inst_pc", inst_pc, 32'h4000_0100);
        run(5);

        // redirect while icache stalled
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0200);
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("pend_addr", icache_addr, 32'h0000_0200);
        check("pend_req_valid", 32'(icache_req_valid), 32'd1);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("pend_accept_addr", icache_addr, 32'h0000_0200);
        run(6);

        // wrap at 2^32
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("wrap_addr", icache_addr, 32'h0000_0000);
        run(6);

        // reset mid-stream
        step();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("rerst_addr", icache_addr, RPC);
        check("rerst_req_valid", 32'(icache_req_valid), 32'd1);
        check("rerst_inst_valid", 32'(inst_valid), 32'd0);
        run(6);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic        r_rst;
            logic        r_kill;
            logic [31:0] r_tgt;
            r_rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            r_kill = ($urandom_range(0, 99) < 6);
            r_tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) r_tgt = 32'hFFFF_FFF0 | (r_tgt & 32'hC);
            step();
            drive(r_rst, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) < 7), r_kill, r_tgt);
        end
        run(10);
        check("liveness", 32'(pops >= 150), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
